// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO port controller: default geometry and register map.
package gpio_pkg;

    localparam int GPIO_WIDTH       = 16;
    localparam int GPIO_SYNC_STAGES = 2;

    localparam logic [2:0] ADDR_OUT    = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_IN     = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_IRQ_EN = 3'd4;

endpackage

// File: rtl/gpio_port_ctrl_if.sv
// CPU-side register bus of the GPIO port controller.
interface gpio_port_ctrl_if
    import gpio_pkg::*;
#(
    parameter int WIDTH = GPIO_WIDTH
);

    // Bus protocol: no backpressure. Each cycle with we=1 is exactly one write,
    // committed at the next rising clk edge. rdata is combinational from the
    // register state for the current addr (zero latency), regardless of we.
    logic [2:0]       addr;
    logic             we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;

    modport master (
        output addr,
        output we,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  we,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/gpio_sync_edge.sv
// Multi-stage synchronizer for the pin readback plus a rising-edge detector that
// stays masked until the pipeline has refilled after reset.
module gpio_sync_edge
    import gpio_pkg::*;
#(
    parameter int WIDTH       = GPIO_WIDTH,
    parameter int SYNC_STAGES = GPIO_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_pin,
    output logic [WIDTH-1:0] o_in,
    output logic [WIDTH-1:0] o_rise
);

    localparam int WARM_CYCLES = SYNC_STAGES + 1;
    localparam int CNT_W       = $clog2(WARM_CYCLES + 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [CNT_W-1:0] r_warm_cnt;
    logic             w_warm_done;

    assign w_warm_done = (r_warm_cnt == CNT_W'(WARM_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev     <= '0;
            r_warm_cnt <= '0;
        end else begin
            r_sync[0] <= i_pin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
            if (!w_warm_done) begin
                r_warm_cnt <= r_warm_cnt + CNT_W'(1);
            end
        end
    end

    assign o_in = r_sync[SYNC_STAGES-1];

    // Pins already high at reset release would otherwise look like fresh edges.
    assign o_rise = w_warm_done ? (o_in & ~r_prev) : '0;

endmodule

// File: rtl/gpio_port_ctrl.sv
// GPIO port controller: OUT/DIR drive the tristate buffer, synchronized readback
// feeds sticky W1C rising-edge flags and a level interrupt.
module gpio_port_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH       = GPIO_WIDTH,
    parameter int SYNC_STAGES = GPIO_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    gpio_port_ctrl_if.slave  bus,
    output logic [WIDTH-1:0] pin_dataW,
    output logic             pin_dir,
    input  logic [WIDTH-1:0] pin_dataR,
    output logic             irq
);

    logic [WIDTH-1:0] r_out;
    logic             r_dir;
    logic [WIDTH-1:0] r_irq_en;
    logic [WIDTH-1:0] r_edge;

    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr_out;
    logic             w_wr_dir;
    logic             w_wr_edge;
    logic             w_wr_irq_en;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_pin  (pin_dataR),
        .o_in   (w_in),
        .o_rise (w_rise)
    );

    assign w_wr_out    = bus.we && (bus.addr == ADDR_OUT);
    assign w_wr_dir    = bus.we && (bus.addr == ADDR_DIR);
    assign w_wr_edge   = bus.we && (bus.addr == ADDR_EDGE);
    assign w_wr_irq_en = bus.we && (bus.addr == ADDR_IRQ_EN);
    assign w_clr       = w_wr_edge ? bus.wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out    <= '0;
            r_dir    <= 1'b0;
            r_irq_en <= '0;
            r_edge   <= '0;
        end else begin
            if (w_wr_out) begin
                r_out <= bus.wdata;
            end
            if (w_wr_dir) begin
                r_dir <= bus.wdata[0];
            end
            if (w_wr_irq_en) begin
                r_irq_en <= bus.wdata;
            end
            // A new edge beats a simultaneous clear of the same bit.
            r_edge <= w_rise | (r_edge & ~w_clr);
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            ADDR_OUT:    bus.rdata = r_out;
            ADDR_DIR:    bus.rdata = WIDTH'(r_dir);
            ADDR_IN:     bus.rdata = w_in;
            ADDR_EDGE:   bus.rdata = r_edge;
            ADDR_IRQ_EN: bus.rdata = r_irq_en;
            default:     bus.rdata = '0;
        endcase
    end

    assign pin_dataW = r_out;
    assign pin_dir   = r_dir;
    assign irq       = |(r_edge & r_irq_en);

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Self-checking bench for gpio_port_ctrl: directed scenarios plus randomized traffic
// compared against a pin-history reference model.
module tb_gpio_port_ctrl;
    import gpio_pkg::*;

    localparam int W    = 16;
    localparam int SYNC = 2;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] pin_dataW;
    logic         pin_dir;
    logic [W-1:0] pin_dataR = '0;
    logic         irq;
    bit           loop_en   = 1'b0;

    int checks = 0;
    int errors = 0;

    gpio_port_ctrl_if #(.WIDTH(W)) bus ();

    gpio_port_ctrl #(
        .WIDTH       (W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .pin_dataW (pin_dataW),
        .pin_dir   (pin_dir),
        .pin_dataR (pin_dataR),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Reference model: history of pin samples, IN/edges derived from it by index.
    logic [W-1:0] hist [$];
    int           n_edges  = 0;
    logic [W-1:0] m_out    = '0;
    logic         m_dir    = 1'b0;
    logic [W-1:0] m_irq_en = '0;
    logic [W-1:0] m_edge   = '0;
    logic [W-1:0] m_rise   = '0;
    logic [W-1:0] m_clr    = '0;

    function automatic logic [W-1:0] in_after(int n);
        if (n < SYNC) return '0;
        return hist[n-SYNC];
    endfunction

    function automatic logic [W-1:0] exp_rd(logic [2:0] a);
        case (a)
            ADDR_OUT:    return m_out;
            ADDR_DIR:    return W'(m_dir);
            ADDR_IN:     return in_after(n_edges);
            ADDR_EDGE:   return m_edge;
            ADDR_IRQ_EN: return m_irq_en;
            default:     return '0;
        endcase
    endfunction

    function automatic logic exp_irq();
        return |(m_edge & m_irq_en);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            n_edges  = 0;
            m_out    = '0;
            m_dir    = 1'b0;
            m_irq_en = '0;
            m_edge   = '0;
        end else begin
            hist.push_back(pin_dataR);
            n_edges++;
            m_rise = (n_edges >= SYNC + 2) ? (in_after(n_edges-1) & ~in_after(n_edges-2)) : '0;
            m_clr  = (bus.we && bus.addr == ADDR_EDGE) ? bus.wdata : '0;
            if (bus.we) begin
                case (bus.addr)
                    ADDR_OUT:    m_out    = bus.wdata;
                    ADDR_DIR:    m_dir    = bus.wdata[0];
                    ADDR_IRQ_EN: m_irq_en = bus.wdata;
                    default:     ;
                endcase
            end
            m_edge = m_rise | (m_edge & ~m_clr);
        end
    end

    // Driver tasks: everything changes on the falling edge.
    task automatic step();
        @(negedge clk);
        if (loop_en && pin_dir) pin_dataR = pin_dataW;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [W-1:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        step();
        bus.we    = 1'b0;
    endtask

    task automatic test_reset();
        bus.addr  = '0;
        bus.we    = 1'b0;
        bus.wdata = '0;
        pin_dataR = 16'hFFFF;
        rst_n     = 1'b0;
        for (int a = 0; a < 8; a++) begin
            step();
            bus.addr = a[2:0];
            #1;
            checks++;
            if (bus.rdata !== 16'h0000) begin
                errors++;
                $display("FAIL reset_rdata addr=%0d got=%h exp=0000", a, bus.rdata);
            end
        end
        checks++;
        if (pin_dir !== 1'b0 || pin_dataW !== 16'h0000 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_pins dir=%b dataW=%h irq=%b exp=0/0000/0", pin_dir, pin_dataW, irq);
        end
        step();
        rst_n = 1'b1;
        repeat (8) step();
        bus.addr = ADDR_EDGE;
        #1;
        checks++;
        if (bus.rdata !== 16'h0000) begin
            errors++;
            $display("FAIL warmup_edge got=%h exp=0000", bus.rdata);
        end
        step();
        bus.addr = ADDR_IN;
        #1;
        checks++;
        if (bus.rdata !== 16'hFFFF) begin
            errors++;
            $display("FAIL warmup_in got=%h exp=ffff", bus.rdata);
        end
    endtask

    task automatic test_loopback();
        logic [W-1:0] exp_in [4];
        logic [W-1:0] exp_edge [4];
        exp_in   = '{16'h0000, 16'hA5C3, 16'hA5C3, 16'hA5C3};
        exp_edge = '{16'h0000, 16'h0000, 16'hA5C3, 16'hA5C3};
        pin_dataR = '0;
        loop_en   = 1'b1;
        repeat (4) step();
        do_write(ADDR_EDGE, 16'hFFFF);
        do_write(ADDR_OUT, 16'hA5C3);
        #1;
        checks++;
        if (pin_dataW !== 16'hA5C3 || pin_dir !== 1'b0) begin
            errors++;
            $display("FAIL loop_out dataW=%h dir=%b exp=a5c3/0", pin_dataW, pin_dir);
        end
        do_write(ADDR_DIR, 16'h0001);
        #1;
        checks++;
        if (pin_dir !== 1'b1) begin
            errors++;
            $display("FAIL loop_dir got=%b exp=1", pin_dir);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            bus.addr = ADDR_IN;
            #1;
            checks++;
            if (bus.rdata !== exp_in[i]) begin
                errors++;
                $display("FAIL loop_in cyc=%0d got=%h exp=%h", i, bus.rdata, exp_in[i]);
            end
            bus.addr = ADDR_EDGE;
            #1;
            checks++;
            if (bus.rdata !== exp_edge[i]) begin
                errors++;
                $display("FAIL loop_edge cyc=%0d got=%h exp=%h", i, bus.rdata, exp_edge[i]);
            end
        end
        loop_en = 1'b0;
        do_write(ADDR_DIR, 16'h0000);
        do_write(ADDR_EDGE, 16'hFFFF);
        bus.addr = ADDR_EDGE;
        #1;
        checks++;
        if (bus.rdata !== 16'h0000 || irq !== 1'b0) begin
            errors++;
            $display("FAIL loop_clear edge=%h irq=%b exp=0000/0", bus.rdata, irq);
        end
    endtask

    task automatic test_irq_edge();
        logic exp_i [3];
        exp_i = '{1'b0, 1'b0, 1'b1};
        pin_dataR = '0;
        do_write(ADDR_IRQ_EN, 16'h0010);
        repeat (3) step();
        do_write(ADDR_EDGE, 16'hFFFF);
        pin_dataR = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            checks++;
            if (irq !== exp_i[i]) begin
                errors++;
                $display("FAIL irq_latency cyc=%0d got=%b exp=%b", i, irq, exp_i[i]);
            end
        end
        bus.addr = ADDR_EDGE;
        #1;
        checks++;
        if (bus.rdata !== 16'h0010) begin
            errors++;
            $display("FAIL irq_edge_flag got=%h exp=0010", bus.rdata);
        end
        do_write(ADDR_EDGE, 16'h0010);
        bus.addr = ADDR_EDGE;
        #1;
        checks++;
        if (bus.rdata !== 16'h0000 || irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_w1c edge=%h irq=%b exp=0000/0", bus.rdata, irq);
        end
    endtask

    task automatic test_w1c_collision();
        do_write(ADDR_IRQ_EN, 16'h0004);
        pin_dataR = 16'h0014;
        step();
        step();
        bus.addr  = ADDR_EDGE;
        bus.wdata = 16'h0004;
        bus.we    = 1'b1;
        step();
        bus.we    = 1'b0;
        #1;
        checks++;
        if (bus.rdata !== 16'h0004 || irq !== 1'b1) begin
            errors++;
            $display("FAIL collision_set_wins edge=%h irq=%b exp=0004/1", bus.rdata, irq);
        end
        do_write(ADDR_EDGE, 16'h0004);
        bus.addr = ADDR_EDGE;
        #1;
        checks++;
        if (bus.rdata !== 16'h0000 || irq !== 1'b0) begin
            errors++;
            $display("FAIL collision_clear edge=%h irq=%b exp=0000/0", bus.rdata, irq);
        end
    endtask

    task automatic test_reg_map();
        logic [2:0]   rd_a [7];
        logic [W-1:0] rd_e [7];
        rd_a = '{3'd1, 3'd6, 3'd0, 3'd4, 3'd2, 3'd5, 3'd7};
        rd_e = '{16'h0001, 16'h0000, 16'h1357, 16'h2468, 16'h0014, 16'h0000, 16'h0000};
        do_write(ADDR_OUT, 16'h1357);
        do_write(ADDR_IRQ_EN, 16'h2468);
        do_write(ADDR_DIR, 16'hFFFF);
        do_write(3'd6, 16'hFFFF);
        do_write(ADDR_IN, 16'hBEEF);
        do_write(3'd5, 16'hFFFF);
        do_write(3'd7, 16'hFFFF);
        for (int i = 0; i < 7; i++) begin
            step();
            bus.addr = rd_a[i];
            #1;
            checks++;
            if (bus.rdata !== rd_e[i]) begin
                errors++;
                $display("FAIL regmap addr=%0d got=%h exp=%h", rd_a[i], bus.rdata, rd_e[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.addr  = 3'($urandom_range(0, 7));
            bus.we    = 1'($urandom_range(0, 1));
            bus.wdata = W'($urandom);
            if ($urandom_range(0, 3) == 0) pin_dataR = W'($urandom);
            #1;
            checks++;
            if (bus.rdata !== exp_rd(bus.addr)) begin
                errors++;
                $display("FAIL rand_rdata cyc=%0d addr=%0d got=%h exp=%h", i, bus.addr, bus.rdata, exp_rd(bus.addr));
            end
            checks++;
            if (pin_dataW !== m_out || pin_dir !== m_dir || irq !== exp_irq()) begin
                errors++;
                $display("FAIL rand_outputs cyc=%0d dataW=%h dir=%b irq=%b exp=%h/%b/%b",
                         i, pin_dataW, pin_dir, irq, m_out, m_dir, exp_irq());
            end
            step();
        end
        bus.we = 1'b0;
    endtask

    task automatic test_async_reset();
        pin_dataR = '0;
        repeat (3) step();
        do_write(ADDR_EDGE, 16'hFFFF);
        do_write(ADDR_IRQ_EN, 16'h00FF);
        do_write(ADDR_DIR, 16'h0001);
        pin_dataR = 16'h00FF;
        repeat (4) step();
        bus.addr = ADDR_EDGE;
        #1;
        checks++;
        if (bus.rdata !== 16'h00FF || irq !== 1'b1 || pin_dir !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup edge=%h irq=%b dir=%b exp=00ff/1/1", bus.rdata, irq, pin_dir);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rdata !== 16'h0000 || irq !== 1'b0 || pin_dir !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate edge=%h irq=%b dir=%b exp=0000/0/0", bus.rdata, irq, pin_dir);
        end
        step();
        rst_n = 1'b1;
        repeat (6) step();
        bus.addr = ADDR_EDGE;
        #1;
        checks++;
        if (bus.rdata !== 16'h0000 || irq !== 1'b0) begin
            errors++;
            $display("FAIL areset_warmup edge=%h irq=%b exp=0000/0", bus.rdata, irq);
        end
        step();
        bus.addr = ADDR_IN;
        #1;
        checks++;
        if (bus.rdata !== exp_rd(ADDR_IN)) begin
            errors++;
            $display("FAIL areset_in got=%h exp=%h", bus.rdata, exp_rd(ADDR_IN));
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_irq_edge();
        test_w1c_collision();
        test_reg_map();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
